pio_debounce_irq: RTL and testbench
===================================

// Module: pio_debounce_irq
// PURPOSE
//   Parametrised Avalon-MM PIO peripheral for the Nios II system: a debounced, edge-capturing
//   input port (push-buttons) and a set/clear-able output port (LEDs). It replaces the fixed
//   3-in/10-out PIO pair and adds per-channel debouncing, edge capture, a masked IRQ and
//   atomic bit set/clear. Connected as an Avalon-MM slave on the Nios data master.
// PARAMETERS
//   IN_WIDTH          3      input channels, 1..32
//   OUT_WIDTH         10     output channels, 1..32
//   DEBOUNCE_CYCLES   50000  clocks an input must stay at its new level before it is accepted, >=2
//   SYNC_STAGES       2      synchroniser flops per input, >=2
//   INPUT_ACTIVE_LOW  1      1: raw pin low = logical 1 (inverted after the synchroniser)
//   EDGE_MODE         0      edge that sets capture: 0 rising, 1 falling, 2 both (logical level)
//   OUT_RESET         0      reset value of the output register [OUT_WIDTH-1:0]
// PORTS
//   clk         in   1          system clock
//   reset       in   1          asynchronous, active-high reset
//   address     in   3          word address
//   read        in   1          Avalon read strobe
//   write       in   1          Avalon write strobe
//   writedata   in   32         write data; full-word writes only, no byteenable
//   readdata    out  32         read data, valid exactly 1 cycle after read
//   irq         out  1          level interrupt = |(edge_cap & irq_mask)
//   pio_in      in   IN_WIDTH   raw asynchronous inputs (buttons)
//   pio_out     out  OUT_WIDTH  registered outputs (LEDs)
// BEHAVIOUR
// - Register map (word addresses). Unused upper bits read as 0.
//   0 DATA_IN RO: debounced level. 1 DATA_OUT RW. 2 IRQ_MASK RW. 3 EDGE_CAP RO, write-1-to-clear.
//   4 OUT_SET WO: DATA_OUT |= wd. 5 OUT_CLR WO: DATA_OUT &= ~wd.
//   6 INFO RO: {8'h01, 8'd0, OUT_WIDTH[7:0], IN_WIDTH[7:0]}. 7 reserved.
//   Reads of WO or reserved addresses return 0. Writes to RO or reserved addresses are ignored.
// - Reset (async assert, sync deassert handled upstream):
//   pio_out=OUT_RESET, readdata=0, irq=0, irq_mask=0, edge_cap=0, debounce counters=0,
//   stable level=0. Synchroniser flops are reset to the raw inactive level
//   (1 if INPUT_ACTIVE_LOW), so that no spurious edge occurs after reset.
// - Avalon: fixed read latency 1, no waitrequest. Writes take effect on the clock edge at
//   which write is sampled. If read and write are asserted together, the write executes
//   and readdata returns the pre-write value.
// - Per-channel debounce. s = synchronised, polarity-corrected input.
//   - s == stable: the counter is cleared.
//   - s != stable: the counter increments each cycle. When the counter equals
//     DEBOUNCE_CYCLES-1 and s still differs, stable<=s and the counter clears on that edge.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
//   - Latency from pin change to DATA_IN is SYNC_STAGES+DEBOUNCE_CYCLES clocks.
//   - Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps.
// - Edge capture: edge_cap[i] is set on the cycle after stable[i] changes in the direction
//   selected by EDGE_MODE. Bits are sticky until a W1C write to address 3.
//   If a W1C write and a new edge for the same bit occur in the same cycle, set wins.
// - irq is combinational from the edge_cap and irq_mask flops. It is asserted while any
//   unmasked captured bit is 1. Changing irq_mask affects irq in the next cycle.
// - Bits of writedata above OUT_WIDTH/IN_WIDTH are ignored.
// - Reset asserted mid-debounce or mid-read: everything returns to the reset values
//   immediately, and the pending read returns 0.
// TESTING
// - Reset: after reset, read addr 1 -> OUT_RESET; addr 0 -> 0; addr 3 -> 0; addr 6 ->
//   32'h0100_0A03 (defaults). irq=0.
// - Debounce (DEBOUNCE_CYCLES=8): pio_in[0] 1->0 held -> DATA_IN[0]=1 exactly 10 clocks later.
//   A 7-cycle low pulse -> DATA_IN stays 0 and edge_cap stays 0.
// - Edge+IRQ: irq_mask=1; press ch0 -> edge_cap=1 and irq=1.
//   Write 1 to addr 3 -> irq=0 next cycle. Repeat with mask=0 -> edge_cap=1, irq=0.
// - Set/clr: write DATA_OUT=0x00F. Then OUT_SET 0x300 -> pio_out=0x30F.
//   Then OUT_CLR 0x005 -> 0x30A. Writedata 0xFFFF_FFFF to addr 1 -> 0x3FF.
// - Collision: W1C on addr 3 in the same cycle as a new ch1 edge -> edge_cap[1]=1 afterwards.
// - Async reset mid-debounce (counter=5) -> counter=0, pio_out=OUT_RESET, and no edge after
//   release with the pin held inactive.

Source files
------------

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO: debounced edge-capturing inputs with masked IRQ, set/clear-able outputs.
// Read latency 1 clock, no waitrequest; input pin to DATA_IN latency SYNC_STAGES+DEBOUNCE_CYCLES.
// Never stalls the bus: every read/write completes in the cycle it is sampled.
module pio_debounce_irq #(
  parameter int IN_WIDTH         = 3,
  parameter int OUT_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int SYNC_STAGES      = 2,
  parameter int INPUT_ACTIVE_LOW = 1,
  parameter int EDGE_MODE        = 0,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level that corresponds to "not pressed"; synchronisers start here so
  // that leaving reset never looks like a press.
  localparam logic [IN_WIDTH-1:0] RAW_IDLE =
      (INPUT_ACTIVE_LOW != 0) ? {IN_WIDTH{1'b1}} : {IN_WIDTH{1'b0}};

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_IRQ_MASK = 3'd2;
  localparam logic [2:0] A_EDGE_CAP = 3'd3;
  localparam logic [2:0] A_OUT_SET  = 3'd4;
  localparam logic [2:0] A_OUT_CLR  = 3'd5;
  localparam logic [2:0] A_INFO     = 3'd6;

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync;
  logic [IN_WIDTH-1:0]                  s;
  logic [IN_WIDTH-1:0][CW-1:0]          cnt;
  logic [IN_WIDTH-1:0]                  stable;
  logic [IN_WIDTH-1:0]                  stable_d;
  logic [IN_WIDTH-1:0]                  new_edge;
  logic [IN_WIDTH-1:0]                  edge_cap;
  logic [IN_WIDTH-1:0]                  edge_clr;
  logic [IN_WIDTH-1:0]                  irq_mask;
  logic [OUT_WIDTH-1:0]                 data_out;
  logic [31:0]                          rd_mux;
  logic                                 unused_wd;

  // Upper writedata bits beyond the channel widths carry no meaning here.
  assign unused_wd = ^writedata;

  // Metastability synchroniser chain, stage 0 samples the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= {SYNC_STAGES{RAW_IDLE}};
    else       sync <= {sync[SYNC_STAGES-2:0], pio_in};
  end

  assign s = (INPUT_ACTIVE_LOW != 0) ? ~sync[SYNC_STAGES-1] : sync[SYNC_STAGES-1];

  // Per-channel debounce: accept a new level only after it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_d <= '0;
    else       stable_d <= stable;
  end

  // Select which debounced transition counts as an event.
  always_comb begin
    new_edge = '0;
    case (EDGE_MODE)
      0:       new_edge = stable & ~stable_d;
      1:       new_edge = ~stable & stable_d;
      default: new_edge = stable ^ stable_d;
    endcase
  end

  assign edge_clr = (write && address == A_EDGE_CAP) ? writedata[IN_WIDTH-1:0] : '0;

  // Sticky edge capture; a fresh edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~edge_clr) | new_edge;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             irq_mask <= '0;
    else if (write && address == A_IRQ_MASK) irq_mask <= writedata[IN_WIDTH-1:0];
  end

  // Output register with direct, atomic-set and atomic-clear write ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= OUT_RESET;
    end else if (write) begin
      case (address)
        A_DATA_OUT: data_out <= writedata[OUT_WIDTH-1:0];
        A_OUT_SET:  data_out <= data_out | writedata[OUT_WIDTH-1:0];
        A_OUT_CLR:  data_out <= data_out & ~writedata[OUT_WIDTH-1:0];
        default:    data_out <= data_out;
      endcase
    end
  end

  // Read mux built from current state, so a simultaneous write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = stable;
      A_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out;
      A_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
      A_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
      A_INFO:     rd_mux = {8'h01, 8'd0, 8'(OUT_WIDTH), 8'(IN_WIDTH)};
      default:    rd_mux = '0;
    endcase
  end

  // Registered read data, zero when no read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     readdata <= '0;
    else if (read) readdata <= rd_mux;
    else           readdata <= '0;
  end

  assign irq     = |(edge_cap & irq_mask);
  assign pio_out = data_out;

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Directed bench for pio_debounce_irq with DEBOUNCE_CYCLES=8 and default widths.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Buttons are active-low: raw 1 = released, raw 0 = pressed.
module tb_pio_debounce_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  pio_in = 3'b111;
  logic [9:0]  pio_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  pio_debounce_irq #(
    .IN_WIDTH(3), .OUT_WIDTH(10), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2),
    .INPUT_ACTIVE_LOW(1), .EDGE_MODE(0), .OUT_RESET(10'h000)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .pio_in(pio_in), .pio_out(pio_out)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] exp [8];
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0100_0A03, 32'h0};
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
    tests++;
    if (pio_out !== 10'h000) begin fails++; $display("FAIL reset_pio_out got %h want 000", pio_out); end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      tests++;
      if (rd !== exp[a]) begin fails++; $display("FAIL reset_read_a%0d got %h want %h", a, rd, exp[a]); end
    end
  endtask

  task automatic test_debounce;
    // Press ch0 with continuous reads of DATA_IN; stable flips at edge 10,
    // so readdata after edge 10 still shows 0 and after edge 11 shows 1.
    address = 3'd0; read = 1'b1;
    pio_in[0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        tests++;
        if (readdata[0] !== 1'b0) begin fails++; $display("FAIL deb_early got %b want 0", readdata[0]); end
      end
      if (k == 11) begin
        tests++;
        if (readdata[0] !== 1'b1) begin fails++; $display("FAIL deb_latency got %b want 1", readdata[0]); end
      end
    end
    read = 1'b0;
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL deb_edge_cap got %h want 1", rd); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL deb_irq_masked got %b want 0", irq); end
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL deb_w1c got %h want 0", rd); end
    // Release: falling edge only, no capture in rising mode.
    pio_in[0] = 1'b1;
    idle(14);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL deb_release got %h want 0", rd); end
    // 7-cycle glitch must be rejected.
    pio_in[0] = 1'b0;
    idle(7);
    pio_in[0] = 1'b1;
    idle(20);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL glitch_data_in got %h want 0", rd); end
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL glitch_edge_cap got %h want 0", rd); end
  endtask

  task automatic test_edge_irq;
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL irq_mask_read got %h want 1", rd); end
    pio_in[0] = 1'b0;
    idle(14);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h1) begin fails++; $display("FAIL irq_edge_cap got %h want 1", rd); end
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b want 1", irq); end
    bus_write(3'd3, 32'h1);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b want 0", irq); end
    pio_in[0] = 1'b1;
    idle(14);
    bus_write(3'd2, 32'h0);
  endtask

  task automatic test_set_clr;
    bus_write(3'd1, 32'h0000_000F);
    tests++;
    if (pio_out !== 10'h00F) begin fails++; $display("FAIL out_write got %h want 00F", pio_out); end
    bus_write(3'd4, 32'h0000_0300);
    tests++;
    if (pio_out !== 10'h30F) begin fails++; $display("FAIL out_set got %h want 30F", pio_out); end
    bus_write(3'd5, 32'h0000_0005);
    tests++;
    if (pio_out !== 10'h30A) begin fails++; $display("FAIL out_clr got %h want 30A", pio_out); end
    bus_write(3'd1, 32'hFFFF_FFFF);
    tests++;
    if (pio_out !== 10'h3FF) begin fails++; $display("FAIL out_wide got %h want 3FF", pio_out); end
    bus_read(3'd1, rd);
    tests++;
    if (rd !== 32'h0000_03FF) begin fails++; $display("FAIL out_readback got %h want 3FF", rd); end
    // Writes to read-only INFO are ignored.
    bus_write(3'd6, 32'h0);
    bus_read(3'd6, rd);
    tests++;
    if (rd !== 32'h0100_0A03) begin fails++; $display("FAIL info_ro got %h want 01000A03", rd); end
    // Read and write together: old value returned, new value applied.
    address = 3'd1; writedata = 32'h1; read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    tests++;
    if (readdata !== 32'h0000_03FF) begin fails++; $display("FAIL rw_old got %h want 3FF", readdata); end
    tests++;
    if (pio_out !== 10'h001) begin fails++; $display("FAIL rw_new got %h want 001", pio_out); end
  endtask

  task automatic test_collision;
    pio_in[1] = 1'b0;
    idle(14);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h2) begin fails++; $display("FAIL coll_first got %h want 2", rd); end
    pio_in[1] = 1'b1;
    idle(14);
    // Second press: edge_cap[1] re-set at edge 11, same edge as the W1C.
    pio_in[1] = 1'b0;
    idle(10);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h2) begin fails++; $display("FAIL coll_set_wins got %h want 2", rd); end
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL coll_clear_after got %h want 0", rd); end
    pio_in[1] = 1'b1;
    idle(14);
  endtask

  task automatic test_reset_mid;
    bus_write(3'd2, 32'h7);
    pio_in[2] = 1'b0;
    idle(7);
    tests++;
    if (dut.cnt[2] !== 3'd5) begin fails++; $display("FAIL mid_cnt_pre got %0d want 5", dut.cnt[2]); end
    address = 3'd1; read = 1'b1;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (dut.cnt[2] !== 3'd0) begin fails++; $display("FAIL mid_cnt_reset got %0d want 0", dut.cnt[2]); end
    tests++;
    if (pio_out !== 10'h000) begin fails++; $display("FAIL mid_pio_out got %h want 000", pio_out); end
    @(posedge clk); #1;
    tests++;
    if (readdata !== 32'h0) begin fails++; $display("FAIL mid_read got %h want 0", readdata); end
    read = 1'b0;
    pio_in[2] = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(20);
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL mid_no_edge got %h want 0", rd); end
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL mid_data_in got %h want 0", rd); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got %b want 0", irq); end
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);
    test_reset();
    test_debounce();
    test_edge_irq();
    test_set_clr();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
